// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampling UART receiver: start, NB_DATA bits LSB first, optional parity, stop.
// Optional parity check is built when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int NB_SCNT = 5
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
`ifdef UART_RX_PARITY_EN
    , output logic             o_parity_err
`endif
);

    localparam int NB_NCNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [NB_SCNT-1:0]   s_cnt_q, s_cnt_d;
    logic [NB_NCNT-1:0]   n_cnt_q, n_cnt_d;
    logic [NB_DATA-1:0]   shreg_q, shreg_d;
    logic [1:0]           rx_sync_q, rx_sync_d;
    logic [NB_DATA-1:0]   data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
`endif

    assign rx_s      = rx_sync_q[1];
    assign rx_sync_d = {rx_sync_q[0], i_rx};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            s_cnt_q   <= '0;
            n_cnt_q   <= '0;
            shreg_q   <= '0;
            rx_sync_q <= 2'b11;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            n_cnt_q   <= n_cnt_d;
            shreg_q   <= shreg_d;
            rx_sync_q <= rx_sync_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = perr_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Leaving IDLE is the only transition that does not wait for a tick.
                if (!rx_s) begin
                    state_d = S_START;
                    s_cnt_d = '0;
                end
            end
            S_START: begin
                if (i_tick) begin
                    if (s_cnt_q == NB_SCNT'(7)) begin
                        if (!rx_s) begin
                            state_d = S_DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + NB_SCNT'(1);
                    end
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (s_cnt_q == NB_SCNT'(15)) begin
                        shreg_d = {rx_s, shreg_q[NB_DATA-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == NB_NCNT'(NB_DATA - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + NB_NCNT'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + NB_SCNT'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (i_tick) begin
                    if (s_cnt_q == NB_SCNT'(15)) begin
                        par_bit_d = rx_s;
                        s_cnt_d   = '0;
                        state_d   = S_STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + NB_SCNT'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (i_tick) begin
                    if (s_cnt_q == NB_SCNT'(SB_TICK - 1)) begin
                        data_d  = shreg_q;
                        ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ((^shreg_q) ^ par_bit_q) != PARITY_ODD;
`endif
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + NB_SCNT'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif

endmodule
